// File: rtl/rsp_s2_prep_ahb_pkg.sv
// Shared AHB-Lite encodings and the register-bank responder state encoding
// for the rsp_s2_prep interconnect responders.
package rsp_s2_prep_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } regbank_state_e;

    // NONSEQ and SEQ both carry a data phase; IDLE and BUSY never do.
    function automatic logic is_trans_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/rsp_s2_prep_ahb_bytestrb.sv
// Byte-lane strobe decode for 32-bit AHB-Lite responders: HSIZE plus
// HADDR[1:0] gives the lanes touched by a transfer (0 for unsupported sizes).
module rsp_s2_prep_ahb_bytestrb
    import rsp_s2_prep_ahb_pkg::*;
(
    input  logic [2:0] i_size,
    input  logic [1:0] i_offset,
    output logic [3:0] o_strb
);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        o_strb = 4'b0000;
        case (i_size)
            HSIZE_BYTE: o_strb = 4'b0001 << i_offset;
            HSIZE_HALF: o_strb = i_offset[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: o_strb = 4'b1111;
            default:    o_strb = 4'b0000;
        endcase
    end

endmodule

// File: rtl/rsp_s2_prep_ahbl_regbank.sv
// AHB-Lite register-bank responder for one rsp_s2_prep MI port: NUM_REGS x 32-bit
// registers, byte-lane writes, WAIT_CYCLES wait states, two-cycle ERROR response.
// Optional macro RSP_S2_PREP_REGBANK_PRIV_EN: user-mode writes to the upper half error.
module rsp_s2_prep_ahbl_regbank
    import rsp_s2_prep_ahb_pkg::*;
#(
    parameter int          NUM_REGS    = 16,
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     HSEL,
    input  logic [ADDR_W-1:0]        HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HWRITE,
    input  logic [2:0]               HSIZE,
    input  logic [3:0]               HPROT,
    input  logic [31:0]              HWDATA,
    input  logic                     HREADY,
    output logic [31:0]              HRDATA,
    output logic                     HREADYOUT,
    output logic                     HRESP,
    output logic [32*NUM_REGS-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr
);

    localparam int         IDX_W     = ADDR_W - 2;
    localparam logic [2:0] WAIT_LOAD = 3'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    regbank_state_e   r_state;
    regbank_state_e   w_state_nxt;
    logic [2:0]       r_cnt;
    logic [2:0]       w_cnt_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_strb;
    logic             r_write;
    logic [31:0]      r_regs [NUM_REGS];

    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_strb;
    logic             w_accept;
    logic             w_err;
    logic             w_commit;
    logic             w_unused;

    assign w_idx    = HADDR[ADDR_W-1:2];
    assign w_unused = &{1'b0, HTRANS[0], HPROT};

    // A new address phase is only taken when no earlier data phase is stalling the bus.
    assign w_accept = HSEL & HREADY & is_trans_active(HTRANS)
                    & (r_state inside {ST_IDLE, ST_DATA, ST_ERR2});

    rsp_s2_prep_ahb_bytestrb u_bytestrb (
        .i_size   (HSIZE),
        .i_offset (HADDR[1:0]),
        .o_strb   (w_strb)
    );

    always_comb begin
        w_err = 1'b0;
        if (32'(w_idx) >= NUM_REGS)                           w_err = 1'b1;
        if (HSIZE > HSIZE_WORD)                               w_err = 1'b1;
        if (HSIZE == HSIZE_HALF && HADDR[0])                  w_err = 1'b1;
        if (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00)       w_err = 1'b1;
`ifdef RSP_S2_PREP_REGBANK_PRIV_EN
        if (HWRITE && !HPROT[1] && 32'(w_idx) >= NUM_REGS / 2) w_err = 1'b1;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_WAIT: begin
                if (r_cnt == 3'd0) w_state_nxt = ST_DATA;
                else               w_cnt_nxt   = r_cnt - 3'd1;
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: begin
                if (!w_accept) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_err) begin
                    w_state_nxt = ST_ERR1;
                end else if (WAIT_CYCLES == 0) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = WAIT_LOAD;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_idx   <= '0;
            r_strb  <= 4'b0000;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_idx   <= w_idx;
                r_strb  <= w_strb;
                r_write <= HWRITE;
            end
        end
    end

    assign w_commit  = (r_state == ST_DATA) && r_write;
    assign HREADYOUT = !(r_state == ST_WAIT || r_state == ST_ERR1);
    assign HRESP     = (r_state == ST_ERR1 || r_state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

    // NOTE: the bank is a set of control flops, not a RAM, so it is reset;
    // consumers see RESET_VAL on reg_q from the moment HRESETn asserts.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (r_strb[b]) r_regs[i][8*b +: 8] <= HWDATA[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        HRDATA = '0;
        if (r_state == ST_DATA && !r_write) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (r_idx == IDX_W'(i)) HRDATA = r_regs[i];
            end
        end
    end

    always_comb begin
        reg_wr = '0;
        for (int i = 0; i < NUM_REGS; i++) reg_wr[i] = w_commit && (r_idx == IDX_W'(i));
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[32*g +: 32] = r_regs[g];
    end

endmodule

// File: tb/tb_rsp_s2_prep_ahbl_regbank.sv
// Bench for rsp_s2_prep_ahbl_regbank: two responders (no-wait and 3-wait) on a
// shared AHB-Lite bus, directed and random transfers against an array model.
module tb_rsp_s2_prep_ahbl_regbank;

    localparam int          N0  = 16;
    localparam int          N1  = 5;
    localparam int          W0  = 0;
    localparam int          W1  = 3;
    localparam logic [31:0] RV0 = 32'h0000_0000;
    localparam logic [31:0] RV1 = 32'hA5A5_0F0F;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [7:0]  HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        hsel0, hsel1, hready_bus;
    logic [31:0] hrdata0, hrdata1;
    logic        hreadyout0, hreadyout1, hresp0, hresp1;
    logic [32*N0-1:0] regq0;
    logic [32*N1-1:0] regq1;
    logic [N0-1:0]    regwr0;
    logic [N1-1:0]    regwr1;

    // Idle responders always report ready, so the AND is the HREADY mux.
    assign hready_bus = hreadyout0 & hreadyout1;

    always #5 HCLK = ~HCLK;

    rsp_s2_prep_ahbl_regbank #(.NUM_REGS(N0), .ADDR_W(8), .WAIT_CYCLES(W0), .RESET_VAL(RV0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(hready_bus),
        .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0), .reg_q(regq0), .reg_wr(regwr0)
    );

    rsp_s2_prep_ahbl_regbank #(.NUM_REGS(N1), .ADDR_W(8), .WAIT_CYCLES(W1), .RESET_VAL(RV1)) u_dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel1), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(hready_bus),
        .HRDATA(hrdata1), .HREADYOUT(hreadyout1), .HRESP(hresp1), .reg_q(regq1), .reg_wr(regwr1)
    );

    typedef struct packed {
        logic        dut;
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [7:0]  addr;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic [31:0] wdata;
    } txn_t;

    txn_t        q[$];
    logic [31:0] mdl [2][64];
    int          n_total = 0;
    int          n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int nregs(input logic d);
        return d ? N1 : N0;
    endfunction

    function automatic int nwait(input logic d);
        return d ? W1 : W0;
    endfunction

    function automatic logic [31:0] rstval(input logic d);
        return d ? RV1 : RV0;
    endfunction

    function automatic logic get_ready(input logic d);
        return d ? hreadyout1 : hreadyout0;
    endfunction

    function automatic logic get_resp(input logic d);
        return d ? hresp1 : hresp0;
    endfunction

    function automatic logic [31:0] get_rdata(input logic d);
        return d ? hrdata1 : hrdata0;
    endfunction

    function automatic logic [63:0] get_wr(input logic d);
        return d ? 64'(regwr1) : 64'(regwr0);
    endfunction

    function automatic logic [31:0] get_q(input logic d, input int i);
        return d ? regq1[32*i +: 32] : regq0[32*i +: 32];
    endfunction

    // ERROR rules written straight from the address-phase decode rules.
    function automatic bit is_err(input txn_t t);
        int idx;
        idx = int'(t.addr[7:2]);
        if (idx >= nregs(t.dut))                   return 1'b1;
        if (t.size > 3'd2)                         return 1'b1;
        if (t.size == 3'd1 && t.addr[0])           return 1'b1;
        if (t.size == 3'd2 && t.addr[1:0] != 2'd0) return 1'b1;
`ifdef RSP_S2_PREP_REGBANK_PRIV_EN
        if (t.wr && !t.prot[1] && idx >= nregs(t.dut) / 2) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // A transfer of 2^size bytes starting at the byte offset replaces those lanes.
    function automatic logic [31:0] merge(input logic [31:0] old, input txn_t t);
        logic [31:0] r;
        int nb;
        int off;
        r   = old;
        nb  = 1 << int'(t.size);
        off = int'(t.addr[1:0]);
        for (int b = 0; b < 4; b++) begin
            if (b >= off && b < off + nb) r[8*b +: 8] = t.wdata[8*b +: 8];
        end
        return r;
    endfunction

    function automatic txn_t idle_txn();
        txn_t t;
        t = '0;
        t.trans = 2'b00;
        return t;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++) mdl[d][i] = rstval(1'(d));
    endtask

    task automatic drive(input txn_t t);
        hsel0  = t.sel && !t.dut;
        hsel1  = t.sel && t.dut;
        HADDR  = t.addr;
        HTRANS = t.trans;
        HWRITE = t.wr;
        HSIZE  = t.size;
        HPROT  = t.prot;
    endtask

    task automatic push(input logic d, input logic wr, input logic [7:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [3:0] prot);
        txn_t t;
        t.dut = d; t.sel = 1'b1; t.trans = 2'b10; t.wr = wr;
        t.addr = a; t.size = sz; t.prot = prot; t.wdata = wd;
        q.push_back(t);
    endtask

    task automatic push_raw(input logic d, input logic sel, input logic [1:0] tr, input logic [7:0] a);
        txn_t t;
        t = '0;
        t.dut = d; t.sel = sel; t.trans = tr; t.addr = a; t.size = 3'd2;
        q.push_back(t);
    endtask

    // Expected outputs of both responders in the current cycle.
    task automatic check_cycle(input bit dp_v, input txn_t dp, input bit dp_err, input int k);
        logic [63:0] e_wr;
        logic [31:0] e_rd;
        logic        e_rdy;
        logic        e_rsp;
        int          idx;
        for (int d = 0; d < 2; d++) begin
            e_wr = '0; e_rd = '0; e_rdy = 1'b1; e_rsp = 1'b0;
            if (dp_v && dp.dut == 1'(d)) begin
                idx   = int'(dp.addr[7:2]);
                e_rdy = (k >= (dp_err ? 1 : nwait(1'(d))));
                e_rsp = dp_err;
                if (e_rdy && !dp_err) begin
                    if (dp.wr) e_wr = 64'(1) << idx;
                    else       e_rd = mdl[d][idx];
                end
            end
            check($sformatf("d%0d_hreadyout", d), 64'(get_ready(1'(d))), 64'(e_rdy));
            check($sformatf("d%0d_hresp", d),     64'(get_resp(1'(d))),  64'(e_rsp));
            check($sformatf("d%0d_hrdata", d),    64'(get_rdata(1'(d))), 64'(e_rd));
            check($sformatf("d%0d_reg_wr", d),    get_wr(1'(d)),         e_wr);
        end
    endtask

    // Pipelined master: address of one transfer overlaps the data phase of the previous.
    task automatic run_q();
        txn_t ap, dp;
        bit   dp_v, dp_err, taken;
        int   k, guard;
        ap = idle_txn(); dp = idle_txn();
        dp_v = 1'b0; dp_err = 1'b0; taken = 1'b1; k = 0; guard = 0;
        forever begin
            @(negedge HCLK);
            check_cycle(dp_v, dp, dp_err, k);
            if (taken) ap = (q.size() > 0) ? q.pop_front() : idle_txn();
            drive(ap);
            HWDATA = dp_v ? dp.wdata : $urandom();
            if (hready_bus) begin
                if (dp_v && dp.wr && !dp_err)
                    mdl[dp.dut][int'(dp.addr[7:2])] = merge(mdl[dp.dut][int'(dp.addr[7:2])], dp);
                dp_v   = ap.sel && ap.trans[1];
                dp     = ap;
                dp_err = dp_v && is_err(ap);
                k      = 0;
                taken  = 1'b1;
            end else begin
                k++;
                taken = 1'b0;
            end
            if (q.size() == 0 && !dp_v && taken) break;
            guard++;
            if (guard > 20000) begin
                check("run_timeout", 64'd1, 64'd0);
                break;
            end
        end
    endtask

    task automatic check_regq(input string tag);
        @(negedge HCLK);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < nregs(1'(d)); i++)
                check($sformatf("%s_reg_q_d%0d_r%0d", tag, d, i), 64'(get_q(1'(d), i)), 64'(mdl[d][i]));
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_d%0d_hreadyout", tag, d), 64'(get_ready(1'(d))), 64'd1);
            check($sformatf("%s_d%0d_hresp", tag, d),     64'(get_resp(1'(d))),  64'd0);
            check($sformatf("%s_d%0d_hrdata", tag, d),    64'(get_rdata(1'(d))), 64'd0);
            check($sformatf("%s_d%0d_reg_wr", tag, d),    get_wr(1'(d)),         64'd0);
            for (int i = 0; i < nregs(1'(d)); i++)
                check($sformatf("%s_d%0d_rst_r%0d", tag, d, i), 64'(get_q(1'(d), i)), 64'(rstval(1'(d))));
        end
    endtask

    initial begin
        txn_t t;
        drive(idle_txn());
        HWDATA = '0;
        model_reset();
        repeat (3) @(negedge HCLK);
        check_reset_outputs("por");
        HRESETn = 1'b1;

        // No-wait responder: reset read, write/read-back, byte lanes, errors, privilege.
        push(1'b0, 1'b0, 8'h0C, 3'd2, 32'h0, 4'b0011);
        push(1'b0, 1'b1, 8'h08, 3'd2, 32'hDEAD_BEEF, 4'b0011);
        push(1'b0, 1'b0, 8'h08, 3'd2, 32'h0, 4'b0011);
        push(1'b0, 1'b1, 8'h04, 3'd2, 32'h1122_3344, 4'b0011);
        push(1'b0, 1'b1, 8'h05, 3'd0, 32'h0000_AA00, 4'b0011);
        push(1'b0, 1'b1, 8'h05, 3'd1, 32'hFFFF_FFFF, 4'b0011);
        push(1'b0, 1'b0, 8'h04, 3'd2, 32'h0, 4'b0011);
        push(1'b0, 1'b0, 8'h40, 3'd2, 32'h0, 4'b0011);
        push(1'b0, 1'b0, 8'h08, 3'd2, 32'h0, 4'b0011);
        push(1'b0, 1'b1, 8'h30, 3'd2, 32'h0BAD_F00D, 4'b0001);
        push(1'b0, 1'b0, 8'h30, 3'd2, 32'h0, 4'b0001);
        push(1'b0, 1'b1, 8'h30, 3'd2, 32'h600D_CAFE, 4'b0011);
        push(1'b0, 1'b0, 8'h30, 3'd2, 32'h0, 4'b0011);
        push(1'b0, 1'b1, 8'h3E, 3'd1, 32'h7788_0000, 4'b0011);
        push(1'b0, 1'b0, 8'h3C, 3'd2, 32'h0, 4'b0011);
        // Three-wait responder: IDLE/BUSY gaps, deselected phase, boundary index, bus hand-over.
        push(1'b1, 1'b0, 8'h00, 3'd2, 32'h0, 4'b0011);
        push_raw(1'b1, 1'b1, 2'b00, 8'h04);
        push(1'b1, 1'b0, 8'h04, 3'd2, 32'h0, 4'b0011);
        push_raw(1'b1, 1'b0, 2'b10, 8'h04);
        push(1'b1, 1'b1, 8'h10, 3'd2, 32'h1234_5678, 4'b0011);
        push(1'b1, 1'b0, 8'h10, 3'd2, 32'h0, 4'b0011);
        push(1'b1, 1'b1, 8'h14, 3'd2, 32'hFFFF_FFFF, 4'b0011);
        push_raw(1'b1, 1'b1, 2'b01, 8'h00);
        push(1'b1, 1'b1, 8'h0A, 3'd1, 32'hBEEF_0000, 4'b0011);
        push(1'b0, 1'b0, 8'h08, 3'd2, 32'h0, 4'b0011);
        push(1'b1, 1'b0, 8'h08, 3'd2, 32'h0, 4'b0011);
        run_q();
        check_regq("directed");

        // Reset during a wait state discards the pending write.
        hsel1 = 1'b1; HADDR = 8'h08; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HPROT = 4'b0011;
        @(negedge HCLK);
        drive(idle_txn());
        HWDATA = 32'hFFFF_FFFF;
        check("midrst_in_wait", 64'(hreadyout1), 64'd0);
        @(negedge HCLK);
        HRESETn = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midrst");
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int i = 0; i < N1; i++) push(1'b1, 1'b0, 8'(4 * i), 3'd2, 32'h0, 4'b0011);
        push(1'b0, 1'b0, 8'h08, 3'd2, 32'h0, 4'b0011);
        run_q();
        check_regq("postrst");

        for (int n = 0; n < 400; n++) begin
            t.dut   = 1'($urandom_range(0, 1));
            t.sel   = ($urandom_range(0, 9) != 0);
            t.trans = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            t.wr    = 1'($urandom_range(0, 1));
            t.size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            t.addr  = 8'($urandom_range(0, nregs(t.dut) * 4 + 7));
            if ($urandom_range(0, 3) != 0) begin
                if (t.size == 3'd2)      t.addr[1:0] = 2'b00;
                else if (t.size == 3'd1) t.addr[0]   = 1'b0;
            end
            t.prot  = 4'($urandom());
            t.wdata = $urandom();
            q.push_back(t);
        end
        run_q();
        check_regq("random");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rsp_s2_prep_ahbl_regbank.md
Name: rsp_s2_prep_ahbl_regbank

Overview:
- AHB-Lite responder (slave) that attaches to one MI port of the rsp_s2_prep interconnect, i.e. the HSELMx/HREADYMUXMx/HREADYOUTMx side.
- Implements NUM_REGS 32-bit control/status registers with byte-lane writes, configurable wait states, and the two-cycle ERROR response.
- Register contents are exported flat to the datapath; per-register write pulses notify consumers of updates.

Parameters:
- NUM_REGS, 16, number of 32-bit registers; legal range 1..64.
- ADDR_W, 8, decoded address width; must satisfy 2^(ADDR_W-2) >= NUM_REGS.
- WAIT_CYCLES, 0, number of HREADYOUT-low cycles inserted per OKAY data phase; legal range 0..7.
- RESET_VAL, 0, reset value applied to every register (32 bits).

Ports:
- HCLK  in  1  AHB clock; all logic is on its rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select (HSELMx).
- HADDR  in  ADDR_W  address, low bits of HADDRMx.
- HTRANS  in  2  transfer type.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size.
- HPROT  in  4  protection; bit 1 = privileged.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus ready (HREADYMUXMx).
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- reg_q  out  32*NUM_REGS  flat register contents; register i occupies bits [32i+31:32i].
- reg_wr  out  NUM_REGS  one-cycle pulse when register i is written.

Behaviour:
- Reset and clocking: one clock (HCLK); asynchronous, active-low reset (HRESETn).
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, reg_wr=0, every register = RESET_VAL, FSM in IDLE.
- Address phase accepted when HSEL & HREADY & HTRANS[1] (NONSEQ or SEQ) → capture index = HADDR[ADDR_W-1:2], byte offset HADDR[1:0], HSIZE and HWRITE.
- IDLE/BUSY transfers, or HSEL=0 with HREADY=1 → no data phase; HREADYOUT=1 and HRESP=0 on the following cycle.
- Error decode, evaluated at the address phase. Any one of these gives ERROR:
  - index >= NUM_REGS;
  - HSIZE > 2;
  - HSIZE=1 with HADDR[0]=1;
  - HSIZE=2 with HADDR[1:0]!=0.
- FSM states:
  - IDLE: no data phase pending.
  - WAIT: OKAY access; HREADYOUT=0 while the wait counter counts down.
  - DATA: completing cycle; HREADYOUT=1, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- FSM transitions:
  - Accepted OKAY access with WAIT_CYCLES=0 → DATA.
  - Accepted OKAY access with WAIT_CYCLES>0 → WAIT, counter loaded with WAIT_CYCLES-1.
  - WAIT → DATA when the counter reaches 0.
  - Error access → ERR1 → ERR2, with no wait states applied.
  - DATA or ERR2 → back-to-back accept if a new address phase is present (HREADY is high in that cycle); otherwise → IDLE.
- Write commit:
  - Happens on the DATA cycle only, into register[index], using byte strobes from HSIZE and offset.
  - reg_wr[index] is asserted during that same cycle.
  - Errored writes never modify state.
- Read data:
  - HRDATA = register[index], combinational from the captured index, during a DATA cycle of a read; 0 otherwise.
  - Full word is returned regardless of size.
- Write followed back-to-back by a read of the same register: the read returns the newly written value, because the write commits before the read's data phase.
- HSEL deasserted while a data phase is pending: the data phase still completes; the slave ignores HSEL outside address phases.
- Reset asserted mid-transfer: immediate return to reset values; the pending write is discarded.

Optional Feature:
- Macro: RSP_S2_PREP_REGBANK_PRIV_EN.
- Defined: a write with HPROT[1]=0 (user mode) to any index >= NUM_REGS/2 takes the ERROR response and the register is unchanged; reads are unaffected.
- Undefined: HPROT is ignored entirely.

Decomposition:
- Package rsp_s2_prep_ahb_pkg holds:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ);
  - HSIZE encodings;
  - HRESP OKAY/ERROR;
  - the FSM state encoding.
- Sub-module rsp_s2_prep_ahb_bytestrb: combinational HSIZE + HADDR[1:0] → 4-bit byte strobe, reusable by other responders.

Test Plan:
- Reset then read reg 3 with WAIT_CYCLES=0, RESET_VAL=0 → HRDATA=0x00000000, HRESP=0, HREADYOUT=1 in the first data cycle.
- Word write 0xDEADBEEF to 0x08, then back-to-back read of 0x08 → read returns 0xDEADBEEF; reg_wr[2] high for exactly one cycle.
- Byte write 0xAA to 0x05 after reg1=0x11223344 → reg1=0x1122AA44; halfword write to 0x05 → ERROR, reg1 unchanged.
- Read of 0x40 with NUM_REGS=16 → HREADYOUT/HRESP sequence (0,1) then (1,1); next transfer accepted in the ERR2 cycle.
- WAIT_CYCLES=3, word read → exactly 3 cycles with HREADYOUT=0, then data plus HREADYOUT=1; an HTRANS=IDLE gap inserts no waits.
- With RSP_S2_PREP_REGBANK_PRIV_EN defined: HPROT=4'b0001 write to reg 12 → ERROR, reg unchanged; HPROT=4'b0011 → OKAY and written.
